apb_req_arbiter: RTL and testbench

- Two-requester APB master that shares one APB slave port, such as the apb_fifo front end of the APB-to-SPI bridge, between two command sources.
- Arbitrates round-robin and sequences each granted request through the APB SETUP and ACCESS phases.
- Returns read data or error to the winning requester.
- Bounds slave wait states with a timeout so a hung slave cannot stall the bus.

---
 rtl/apb_req_arbiter.sv | 111 +++++++++++
 tb/tb_apb_req_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin APB master shared by two requesters; grant, SETUP, ACCESS, then a one-cycle rsp pulse.
// Minimum 3 cycles per transfer; requesters are held off via req_ready, ACCESS bounded by TIMEOUT.
module apb_req_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESET_N,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_write,
    input  logic [2*WIDTH-1:0] req_addr,
    input  logic [2*WIDTH-1:0] req_wdata,
    output logic [1:0]         rsp_valid,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               rsp_err,
    output logic               busy,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [WIDTH-1:0]   PADDR,
    output logic [WIDTH-1:0]   PWDATA,
    input  logic [WIDTH-1:0]   PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state;
    logic            last_grant;
    logic            grant;
    logic [CW-1:0]   cnt;
    logic            any_req;
    logic            win;
    logic            timed_out;

    // With both requesting, the one that did not win last time goes next.
    always_comb begin
        any_req   = |req_valid;
        win       = req_valid[1] & (~req_valid[0] | ~last_grant);
        req_ready = 2'b00;
        if (state == IDLE && any_req) begin
            req_ready[win] = 1'b1;
        end
    end

    // cnt counts completed wait cycles, so it equals TIMEOUT-1 on the last allowed ACCESS cycle.
    assign timed_out = (TIMEOUT != 0) && !PREADY && (cnt == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            cnt        <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= win;
                        last_grant <= win;
                        PWRITE     <= req_write[win];
                        PADDR      <= win ? req_addr[2*WIDTH-1:WIDTH]  : req_addr[WIDTH-1:0];
                        PWDATA     <= win ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];
                        PSEL       <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY || timed_out) begin
                        state     <= IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        busy      <= 1'b0;
                        rsp_valid <= grant ? 2'b10 : 2'b01;
                        rsp_err   <= !PREADY || PSLVERR;
                        rsp_rdata <= (PREADY && !PWRITE && !PSLVERR) ? PRDATA : '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus a randomized transaction-level model.
module tb_apb_req_arbiter;
    localparam int W  = 8;
    localparam int TO = 16;

    logic             PCLK = 1'b0;
    logic             PRESET_N;
    logic [1:0]       req_valid, req_ready, req_write, rsp_valid;
    logic [2*W-1:0]   req_addr, req_wdata;
    logic [W-1:0]     rsp_rdata, PADDR, PWDATA, PRDATA;
    logic             rsp_err, busy, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    int               n_checks = 0;
    int               n_fail   = 0;
    int               slave_wait = 0;
    logic             slave_err = 1'b0;
    logic [W-1:0]     slave_rdata = '0;
    logic             model_last = 1'b1;

    apb_req_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET_N(PRESET_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave: PREADY rises after slave_wait ACCESS cycles; junk on PRDATA/PSLVERR while not ready.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (PSEL && PENABLE) begin
                PREADY = (acc_cnt >= slave_wait);
                acc_cnt++;
            end else begin
                PREADY = 1'b0;
                acc_cnt = 0;
            end
            PRDATA  = PREADY ? slave_rdata : W'($urandom);
            PSLVERR = PREADY ? slave_err : 1'($urandom);
        end
    end

    // Drives one request from a single requester and observes the transfer until its response.
    task automatic run_one(input int r, input logic wr, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                           output logic [1:0] rdy, output int psel_n, output int penable_n, output int lat,
                           output int unstable, output logic [1:0] rv, output logic err,
                           output logic [W-1:0] rdata, output logic end_psel, output logic end_busy);
        @(negedge PCLK);
        req_valid    = 2'b00;
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_addr[r*W +: W]  = addr;
        req_wdata[r*W +: W] = wdata;
        #1 rdy = req_ready;
        model_last = r[0];
        psel_n = 0; penable_n = 0; unstable = 0; lat = 0;
        rv = 2'b00; err = 1'b0; rdata = '0; end_psel = 1'b1; end_busy = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge PCLK);
            req_valid = 2'b00;
            if (rsp_valid != 2'b00) begin
                lat = k; rv = rsp_valid; err = rsp_err; rdata = rsp_rdata;
                end_psel = PSEL; end_busy = busy;
                break;
            end
            if (PSEL) begin
                psel_n++;
                if (PADDR !== addr || PWDATA !== wdata || PWRITE !== wr) unstable++;
            end
            if (PENABLE) penable_n++;
        end
    endtask

    task automatic test_reset();
        PRESET_N = 1'b0;
        req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge PCLK);
        n_checks++; if ({PSEL, PENABLE, PWRITE, busy} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {PSEL, PENABLE, PWRITE, busy}); end
        n_checks++; if ({PADDR, PWDATA} !== '0) begin n_fail++; $display("FAIL reset_addr_data: got %h expected 0", {PADDR, PWDATA}); end
        n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin n_fail++; $display("FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_err, rsp_rdata}); end
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        PRESET_N = 1'b1;
        model_last = 1'b1;
        repeat (2) @(negedge PCLK);
        n_checks++; if ({PSEL, busy} !== 2'b00) begin n_fail++; $display("FAIL idle_no_req: got %b expected 00", {PSEL, busy}); end
    endtask

    task automatic test_single_write();
        logic [1:0] rdy, rv; int ps, pe, lat, uns; logic err, ep, eb; logic [W-1:0] rd;
        slave_wait = 2; slave_err = 1'b0; slave_rdata = 8'h77;
        run_one(0, 1'b1, 8'hAA, 8'hBB, rdy, ps, pe, lat, uns, rv, err, rd, ep, eb);
        n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL wr_ready: got %b expected 01", rdy); end
        n_checks++; if (ps !== 4) begin n_fail++; $display("FAIL wr_psel_cycles: got %0d expected 4", ps); end
        n_checks++; if (pe !== 3) begin n_fail++; $display("FAIL wr_penable_cycles: got %0d expected 3", pe); end
        n_checks++; if (uns !== 0) begin n_fail++; $display("FAIL wr_apb_stable: got %0d bad cycles expected 0", uns); end
        n_checks++; if (rv !== 2'b01) begin n_fail++; $display("FAIL wr_rsp_valid: got %b expected 01", rv); end
        n_checks++; if ({err, rd} !== 9'h000) begin n_fail++; $display("FAIL wr_rsp: got err %b rdata %h expected 0/00", err, rd); end
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL wr_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_single_read();
        logic [1:0] rdy, rv; int ps, pe, lat, uns; logic err, ep, eb; logic [W-1:0] rd;
        slave_wait = 0; slave_err = 1'b0; slave_rdata = 8'h5C;
        run_one(1, 1'b0, 8'h10, 8'h00, rdy, ps, pe, lat, uns, rv, err, rd, ep, eb);
        n_checks++; if (rdy !== 2'b10) begin n_fail++; $display("FAIL rd_ready: got %b expected 10", rdy); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        n_checks++; if (rv !== 2'b10) begin n_fail++; $display("FAIL rd_rsp_valid: got %b expected 10", rv); end
        n_checks++; if ({err, rd} !== {1'b0, 8'h5C}) begin n_fail++; $display("FAIL rd_rsp: got err %b rdata %h expected 0/5c", err, rd); end
        n_checks++; if (pe !== 1) begin n_fail++; $display("FAIL rd_penable_cycles: got %0d expected 1", pe); end
    endtask

    task automatic test_contention();
        int ngr = 0, nrsp0 = 0, nrsp1 = 0, gaps = 0, bad_gaps = 0, low_run = 0;
        logic seen_high = 1'b0, drop = 1'b0, exp_g;
        slave_wait = 1; slave_err = 1'b0; slave_rdata = 8'h42;
        @(negedge PCLK);
        req_write = 2'b01; req_addr = {8'h21, 8'h20}; req_wdata = {8'hB1, 8'hA1};
        req_valid = 2'b11;
        for (int cyc = 0; cyc < 200 && (ngr < 4 || nrsp0 + nrsp1 < 4); cyc++) begin
            #1;
            if (rsp_valid[0]) nrsp0++;
            if (rsp_valid[1]) nrsp1++;
            if (PSEL) begin
                if (seen_high && low_run > 0) begin
                    gaps++;
                    if (low_run != 1) bad_gaps++;
                end
                seen_high = 1'b1; low_run = 0;
            end else begin
                low_run++;
            end
            if (req_ready != 2'b00 && ngr < 4) begin
                exp_g = ~model_last;
                n_checks++; if (req_ready !== (exp_g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL cont_grant%0d: got %b expected %b", ngr, req_ready, exp_g ? 2'b10 : 2'b01); end
                model_last = exp_g;
                ngr++;
                if (ngr == 4) drop = 1'b1;
            end
            @(negedge PCLK);
            if (drop) req_valid = 2'b00;
        end
        req_valid = 2'b00;
        n_checks++; if (ngr !== 4) begin n_fail++; $display("FAIL cont_grants: got %0d expected 4", ngr); end
        n_checks++; if ({nrsp0, nrsp1} !== {32'd2, 32'd2}) begin n_fail++; $display("FAIL cont_rsp_split: got %0d/%0d expected 2/2", nrsp0, nrsp1); end
        n_checks++; if ({gaps, bad_gaps} !== {32'd3, 32'd0}) begin n_fail++; $display("FAIL cont_psel_gaps: got %0d gaps %0d not one cycle expected 3/0", gaps, bad_gaps); end
    endtask

    task automatic test_slave_error();
        logic [1:0] rdy, rv; int ps, pe, lat, uns; logic err, ep, eb; logic [W-1:0] rd;
        slave_wait = 0; slave_err = 1'b1; slave_rdata = 8'hA5;
        run_one(0, 1'b0, 8'h33, 8'h00, rdy, ps, pe, lat, uns, rv, err, rd, ep, eb);
        n_checks++; if ({rv, err, rd} !== {2'b01, 1'b1, 8'h00}) begin n_fail++; $display("FAIL err_rsp: got rv %b err %b rdata %h expected 01/1/00", rv, err, rd); end
        slave_err = 1'b0; slave_rdata = 8'h3C;
        run_one(1, 1'b0, 8'h34, 8'h00, rdy, ps, pe, lat, uns, rv, err, rd, ep, eb);
        n_checks++; if ({rv, err, rd} !== {2'b10, 1'b0, 8'h3C}) begin n_fail++; $display("FAIL err_next_rsp: got rv %b err %b rdata %h expected 10/0/3c", rv, err, rd); end
    endtask

    task automatic test_timeout();
        logic [1:0] rdy, rv; int ps, pe, lat, uns; logic err, ep, eb; logic [W-1:0] rd;
        slave_wait = 1000; slave_err = 1'b0; slave_rdata = 8'hEE;
        run_one(0, 1'b1, 8'h55, 8'h66, rdy, ps, pe, lat, uns, rv, err, rd, ep, eb);
        n_checks++; if (pe !== TO) begin n_fail++; $display("FAIL to_penable_cycles: got %0d expected %0d", pe, TO); end
        n_checks++; if (lat !== TO + 2) begin n_fail++; $display("FAIL to_latency: got %0d expected %0d", lat, TO + 2); end
        n_checks++; if ({rv, err, rd} !== {2'b01, 1'b1, 8'h00}) begin n_fail++; $display("FAIL to_rsp: got rv %b err %b rdata %h expected 01/1/00", rv, err, rd); end
        n_checks++; if ({ep, eb} !== 2'b00) begin n_fail++; $display("FAIL to_release: got psel/busy %b expected 00", {ep, eb}); end
        slave_wait = 1; slave_rdata = 8'h81;
        run_one(1, 1'b0, 8'h56, 8'h00, rdy, ps, pe, lat, uns, rv, err, rd, ep, eb);
        n_checks++; if ({rv, err, rd, lat} !== {2'b10, 1'b0, 8'h81, 32'd4}) begin n_fail++; $display("FAIL to_recover: got rv %b err %b rdata %h lat %0d expected 10/0/81/4", rv, err, rd, lat); end
    endtask

    task automatic test_random();
        logic [1:0] pend = 2'b00, exp_ready, exp_rv;
        int gen = 0, done = 0, since = 0, exp_lat = 0, drop = -1, w;
        logic inflight = 1'b0, exp_err, exp_wr, g, tmo;
        logic [W-1:0] exp_rdata, exp_addr, exp_wdata;
        for (int cyc = 0; cyc < 4000 && (gen < 40 || done < gen); cyc++) begin
            @(negedge PCLK);
            if (inflight) begin
                since++;
                if (rsp_valid != 2'b00) begin
                    n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {exp_rv, exp_err, exp_rdata}) begin n_fail++; $display("FAIL rnd_rsp: got rv %b err %b rdata %h expected %b/%b/%h", rsp_valid, rsp_err, rsp_rdata, exp_rv, exp_err, exp_rdata); end
                    n_checks++; if (since !== exp_lat) begin n_fail++; $display("FAIL rnd_latency: got %0d expected %0d", since, exp_lat); end
                    inflight = 1'b0; done++;
                end else if (since > exp_lat) begin
                    n_checks++; n_fail++; $display("FAIL rnd_rsp_missing: got none after %0d cycles expected at %0d", since, exp_lat);
                    inflight = 1'b0; done++;
                end else begin
                    n_checks++; if ({PWRITE, PADDR, PWDATA, PENABLE} !== {exp_wr, exp_addr, exp_wdata, since > 1}) begin n_fail++; $display("FAIL rnd_apb: got %h expected %h", {PWRITE, PADDR, PWDATA, PENABLE}, {exp_wr, exp_addr, exp_wdata, since > 1}); end
                end
            end else begin
                n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rnd_spurious_rsp: got %b expected 00", rsp_valid); end
            end
            n_checks++; if ({busy, PSEL} !== {2{inflight}}) begin n_fail++; $display("FAIL rnd_busy: got %b expected %b", {busy, PSEL}, {2{inflight}}); end
            if (drop >= 0) begin pend[drop] = 1'b0; req_valid[drop] = 1'b0; drop = -1; end
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && gen < 40 && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1; gen++;
                    req_valid[i] = 1'b1;
                    req_write[i] = 1'($urandom);
                    req_addr[i*W +: W]  = W'($urandom);
                    req_wdata[i*W +: W] = W'($urandom);
                end
            end
            #1;
            exp_ready = 2'b00;
            g = 1'b0;
            if (!inflight && pend != 2'b00) begin
                g = (pend == 2'b11) ? ~model_last : pend[1];
                exp_ready[g] = 1'b1;
            end
            n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_grant: got %b expected %b (pending %b)", req_ready, exp_ready, pend); end
            if (exp_ready != 2'b00) begin
                model_last = g; drop = int'(g); inflight = 1'b1; since = 0;
                exp_wr    = req_write[g];
                exp_addr  = req_addr[int'(g)*W +: W];
                exp_wdata = req_wdata[int'(g)*W +: W];
                w = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 3));
                slave_wait  = w;
                slave_err   = ($urandom_range(0, 3) == 0);
                slave_rdata = W'($urandom);
                tmo       = (w >= TO);
                exp_lat   = 2 + (tmo ? TO : w + 1);
                exp_err   = tmo || slave_err;
                exp_rdata = (tmo || exp_wr || slave_err) ? '0 : slave_rdata;
                exp_rv    = g ? 2'b10 : 2'b01;
            end
        end
        req_valid = 2'b00;
        n_checks++; if ({gen, done} !== {32'd40, 32'd40}) begin n_fail++; $display("FAIL rnd_count: got %0d issued %0d done expected 40/40", gen, done); end
    endtask

    task automatic test_reset_mid_access();
        int spurious = 0, k;
        slave_wait = 1000;
        @(negedge PCLK);
        req_valid = 2'b01; req_write[0] = 1'b1; req_addr[W-1:0] = 8'hC0; req_wdata[W-1:0] = 8'hC1;
        @(negedge PCLK);
        req_valid = 2'b00;
        repeat (3) @(negedge PCLK);
        n_checks++; if ({PSEL, PENABLE, busy} !== 3'b111) begin n_fail++; $display("FAIL rst_pre_access: got %b expected 111", {PSEL, PENABLE, busy}); end
        #2 PRESET_N = 1'b0;
        #1;
        n_checks++; if ({PSEL, PENABLE, busy, rsp_valid} !== 5'b0) begin n_fail++; $display("FAIL rst_async_clear: got %b expected 00000", {PSEL, PENABLE, busy, rsp_valid}); end
        @(negedge PCLK);
        PRESET_N = 1'b1;
        model_last = 1'b1;
        repeat (3) begin
            @(negedge PCLK);
            if (rsp_valid != 2'b00 || PSEL) spurious++;
        end
        n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL rst_no_rsp: got %0d active cycles expected 0", spurious); end
        slave_wait = 0; slave_rdata = 8'h99;
        req_valid = 2'b11; req_write = 2'b00;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant: got %b expected 01", req_ready); end
        @(negedge PCLK);
        req_valid = 2'b00;
        k = 0;
        while (rsp_valid == 2'b00 && k < 20) begin @(negedge PCLK); k++; end
        n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 8'h99}) begin n_fail++; $display("FAIL rst_after_rsp: got rv %b err %b rdata %h expected 01/0/99", rsp_valid, rsp_err, rsp_rdata); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_slave_error();
        test_timeout();
        test_random();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
